// File: rtl/neighborhood_window_gen.sv
// 3x3 binary neighbourhood window generator over a raster pixel stream.
// Emits only interior windows, one cycle after the bottom-right pixel arrives.
module neighborhood_window_gen #(
    parameter int IMG_WIDTH  = 16,
    parameter int IMG_HEIGHT = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_pixel,
    input  logic                          in_sof,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [8:0]                    neighbors_state,
    output logic [$clog2(IMG_HEIGHT)-1:0] out_row,
    output logic [$clog2(IMG_WIDTH)-1:0]  out_col,
    output logic                          out_last
);

    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);

    typedef enum logic {
        FILL,
        STREAM
    } state_e;

    state_e          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   pos_row;
    logic [CW-1:0]   pos_col;
    logic            col_wrap;
    logic            row_wrap;
    logic            accept;
    logic            emit;

    logic [IMG_WIDTH-1:0] lb1_q;
    logic [IMG_WIDTH-1:0] lb2_q;

    // Window columns: bit0 = row r-2, bit1 = row r-1, bit2 = row r.
    logic [2:0]      c1_q;
    logic [2:0]      c2_q;
    logic [2:0]      nc;
    logic [8:0]      win_d;

    logic            out_valid_q;
    logic            out_last_q;
    logic [8:0]      ns_q;
    logic [RW-1:0]   out_row_q;
    logic [CW-1:0]   out_col_q;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // An in_sof pixel overrides the counters and sits at (0,0).
    assign pos_row  = in_sof ? '0 : row_q;
    assign pos_col  = in_sof ? '0 : col_q;
    assign col_wrap = (pos_col == COL_MAX);
    assign row_wrap = (pos_row == ROW_MAX);

    always_comb begin
        col_d = col_wrap ? '0 : pos_col + 1'b1;
        row_d = pos_row;
        if (col_wrap) begin
            row_d = row_wrap ? '0 : pos_row + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (in_sof) begin
            state_d = FILL;
        end else if (state_q == STREAM) begin
            if (row_wrap && col_wrap) begin
                state_d = FILL;
            end
        end else if (pos_row == RW'(1) && col_wrap) begin
            state_d = STREAM;
        end
    end

    assign emit = accept && (state_q == STREAM) && !in_sof
               && (pos_col >= CW'(2));

    assign nc = {in_pixel, lb1_q[pos_col], lb2_q[pos_col]};

    assign win_d = {c1_q[1], c2_q[1], c2_q[2], c1_q[2],
                    nc[2], nc[1], nc[0], c1_q[0], c2_q[0]};

    always_ff @(posedge clk) begin
        if (accept) begin
            lb2_q[pos_col] <= lb1_q[pos_col];
            lb1_q[pos_col] <= in_pixel;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FILL;
            row_q       <= '0;
            col_q       <= '0;
            c1_q        <= '0;
            c2_q        <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            ns_q        <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
        end else begin
            if (accept) begin
                state_q <= state_d;
                row_q   <= row_d;
                col_q   <= col_d;
                c2_q    <= c1_q;
                c1_q    <= nc;
            end
            if (emit) begin
                out_valid_q <= 1'b1;
                ns_q        <= win_d;
                out_row_q   <= pos_row - 1'b1;
                out_col_q   <= pos_col - 1'b1;
                out_last_q  <= row_wrap && col_wrap;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid       = out_valid_q;
    assign out_last        = out_last_q;
    assign neighbors_state = ns_q;
    assign out_row         = out_row_q;
    assign out_col         = out_col_q;

endmodule

// File: tb/tb_neighborhood_window_gen.sv
// Randomised self-checking bench for neighborhood_window_gen on a 4x4 image.
// Expected windows come from a frame-array model indexed by raster position.
module tb_neighborhood_window_gen;

    localparam int W = 4;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_pixel = 1'b0;
    logic       in_sof = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [8:0] neighbors_state;
    logic [1:0] out_row;
    logic [1:0] out_col;
    logic       out_last;

    int n_checks = 0;
    int n_errors = 0;

    neighborhood_window_gen #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pixel       (in_pixel),
        .in_sof         (in_sof),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .neighbors_state(neighbors_state),
        .out_row        (out_row),
        .out_col        (out_col),
        .out_last       (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    bit ready_rand  = 1'b0;
    bit ready_level = 1'b1;

    always @(posedge clk) begin
        #1;
        out_ready = ready_rand ? ($urandom_range(0, 3) != 0) : ready_level;
    end

    // Reference model: image array plus raster index of the next pixel.
    logic        img [H][W];
    int          idx = 0;
    logic [13:0] exp_q[$];
    logic [13:0] obs_q[$];
    bit          prev_stall = 1'b0;
    logic [13:0] prev_out;

    function automatic logic [8:0] win(input int r, input int c);
        return {img[r][c], img[r][c-1], img[r+1][c-1], img[r+1][c],
                img[r+1][c+1], img[r][c+1], img[r-1][c+1], img[r-1][c],
                img[r-1][c-1]};
    endfunction

    always @(negedge clk) begin
        logic [13:0] cur;
        logic [13:0] e;
        int r;
        int c;
        cur = {out_last, out_row, out_col, neighbors_state};
        if (!rst) begin
            exp_q.delete();
            idx = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", {31'd0, out_valid}, 32'd1);
                check("stall_hold", {18'd0, cur}, {18'd0, prev_out});
            end
            if (out_valid && !out_ready) begin
                check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            end
            if (out_valid && out_ready) begin
                obs_q.push_back(cur);
                if (exp_q.size() == 0) begin
                    check("spurious_window", {18'd0, cur}, 32'h3fff_0000);
                end else begin
                    e = exp_q.pop_front();
                    check("window", {18'd0, cur}, {18'd0, e});
                end
            end
            if (in_valid && in_ready) begin
                if (in_sof) idx = 0;
                r = idx / W;
                c = idx % W;
                img[r][c] = in_pixel;
                if (r >= 2 && c >= 2) begin
                    e = {(r == H - 1 && c == W - 1), 2'(r - 1), 2'(c - 1),
                         win(r - 1, c - 1)};
                    exp_q.push_back(e);
                end
                idx = (idx + 1) % (W * H);
            end
            prev_stall = out_valid && !out_ready;
            prev_out = cur;
        end
    end

    task automatic send_px(input logic p, input logic s);
        int n;
        bit acc;
        n = 0;
        in_valid = 1'b1;
        in_pixel = p;
        in_sof = s;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_sof = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] f, input bit gaps);
        for (int i = 0; i < W * H; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                idle();
                @(posedge clk);
                #1;
            end
            send_px(f[i], i == 0);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        idle();
        while ((exp_q.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) check("drain_timeout", 32'd0, 32'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    bit tx_done;

    initial begin
        logic [13:0] ones_exp[4];
        logic [8:0]  dot_exp[4];
        int n;

        ones_exp[0] = {1'b0, 2'd1, 2'd1, 9'h1ff};
        ones_exp[1] = {1'b0, 2'd1, 2'd2, 9'h1ff};
        ones_exp[2] = {1'b0, 2'd2, 2'd1, 9'h1ff};
        ones_exp[3] = {1'b1, 2'd2, 2'd2, 9'h1ff};
        dot_exp[0] = 9'h100;
        dot_exp[1] = 9'h080;
        dot_exp[2] = 9'h002;
        dot_exp[3] = 9'h001;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_ns", {23'd0, neighbors_state}, 32'd0);
        check("rst_row", {30'd0, out_row}, 32'd0);
        check("rst_col", {30'd0, out_col}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;

        obs_q.delete();
        send_frame(16'hffff, 1'b0);
        drain();
        check("ones_count", obs_q.size(), 32'd4);
        for (int i = 0; i < 4 && i < obs_q.size(); i++)
            check("ones_win", {18'd0, obs_q[i]}, {18'd0, ones_exp[i]});

        obs_q.delete();
        send_frame(16'h0020, 1'b0);
        drain();
        check("dot_count", obs_q.size(), 32'd4);
        for (int i = 0; i < 4 && i < obs_q.size(); i++)
            check("dot_win", {23'd0, obs_q[i][8:0]}, {23'd0, dot_exp[i]});

        obs_q.delete();
        ready_level = 1'b0;
        tx_done = 1'b0;
        fork
            begin
                send_frame(16'hffff, 1'b0);
                idle();
                tx_done = 1'b1;
            end
        join_none
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("stall_first_valid", {31'd0, out_valid}, 32'd1);
        repeat (6) @(posedge clk);
        #1;
        check("stall_no_accept", {31'd0, in_ready}, 32'd0);
        ready_level = 1'b1;
        n = 0;
        while (!tx_done && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("stall_tx_done", {31'd0, tx_done}, 32'd1);
        drain();
        check("stall_count", obs_q.size(), 32'd4);
        for (int i = 0; i < 4 && i < obs_q.size(); i++)
            check("stall_win", {18'd0, obs_q[i]}, {18'd0, ones_exp[i]});

        obs_q.delete();
        for (int i = 0; i < 11; i++) send_px(1'b1, i == 0);
        send_px(1'b0, 1'b1);
        for (int i = 1; i < W * H; i++) send_px(1'b0, 1'b0);
        drain();
        check("sof_count", obs_q.size(), 32'd5);
        for (int i = 1; i < 5 && i < obs_q.size(); i++)
            check("sof_zero_win", {23'd0, obs_q[i][8:0]}, 32'd0);

        obs_q.delete();
        for (int i = 0; i < 10; i++) send_px(1'b1, i == 0);
        ready_level = 1'b0;
        send_px(1'b1, 1'b0);
        idle();
        check("mid_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        ready_rand = 1'b1;
        obs_q.delete();
        send_frame(16'($urandom), 1'b1);
        drain();
        check("post_rst_count", obs_q.size(), 32'd4);

        ready_rand = 1'b0;
        ready_level = 1'b1;
        obs_q.delete();
        send_frame(16'($urandom), 1'b0);
        send_frame(16'($urandom), 1'b0);
        drain();
        check("b2b_count", obs_q.size(), 32'd8);
        for (int i = 0; i < 8 && i < obs_q.size(); i++)
            check("b2b_last", {31'd0, obs_q[i][13]},
                  {31'd0, (i == 3 || i == 7)});

        ready_rand = 1'b1;
        for (int k = 0; k < 20; k++) begin
            send_frame(16'($urandom), 1'b1);
            if ($urandom_range(0, 4) == 0) begin
                n = $urandom_range(1, 14);
                for (int i = 0; i < n; i++) send_px(1'($urandom), 1'b0);
            end
        end
        drain();
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
